// File: rtl/muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit: MUL/MULH/MULHSU/MULHU via a latency-counted
// multiplier, DIV/DIVU/REM/REMU via a radix-2 restoring divider on magnitudes.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module muldiv_unit #(
  parameter int WORD_SIZE   = `WORD_SIZE,
  parameter int MUL_LATENCY = 3,
  parameter int TAG_WIDTH   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           funct3,
  input  logic [WORD_SIZE-1:0] aluIn1,
  input  logic [WORD_SIZE-1:0] aluIn2,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_result,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int W       = WORD_SIZE;
  localparam int CNT_MAX = (W > MUL_LATENCY) ? W : MUL_LATENCY;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [1:0]     op_reg, op_next;
  logic [W-1:0]   opa_reg, opa_next;   // multiplicand, or dividend magnitude / quotient shift
  logic [W-1:0]   opb_reg, opb_next;   // multiplier, or divisor magnitude
  logic [W-1:0]   rem_reg, rem_next;
  logic           quo_neg_reg, quo_neg_next;
  logic           rem_neg_reg, rem_neg_next;
  logic [W-1:0]   result_reg, result_next;
  logic [TAG_WIDTH-1:0] tag_reg, tag_next;

  logic           accept;
  logic           div_signed, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic           div_by_zero, overflow;
  logic [W-1:0]   special_result;
  logic [1:0]     mul_op;
  logic [W-1:0]   mul_a, mul_b;
  logic           a_sx, b_sx;
  logic [2*W-1:0] mul_a_ext, mul_b_ext, product;
  logic [W-1:0]   mul_result;
  logic [W:0]     rem_shift, diff;
  logic           q_bit;
  logic [W-1:0]   quo_fix, rem_fix;

  assign in_ready   = (state_reg == IDLE) && !flush;
  assign out_valid  = (state_reg == DONE);
  assign out_result = result_reg;
  assign out_tag    = tag_reg;
  assign accept     = in_valid && in_ready;

  // Division pre-processing on the incoming operands.
  assign div_signed     = !funct3[0];
  assign a_neg          = div_signed && aluIn1[W-1];
  assign b_neg          = div_signed && aluIn2[W-1];
  assign a_mag          = a_neg ? -aluIn1 : aluIn1;
  assign b_mag          = b_neg ? -aluIn2 : aluIn2;
  assign div_by_zero    = (aluIn2 == '0);
  assign overflow       = div_signed && (aluIn1 == {1'b1, {(W-1){1'b0}}}) && (aluIn2 == '1);
  assign special_result = div_by_zero ? (funct3[1] ? aluIn1 : '1)
                                      : (funct3[1] ? '0 : aluIn1);

  // Operands come straight from the inputs only when the latency-1 path is used.
  assign mul_op     = (state_reg == IDLE) ? funct3[1:0] : op_reg;
  assign mul_a      = (state_reg == IDLE) ? aluIn1 : opa_reg;
  assign mul_b      = (state_reg == IDLE) ? aluIn2 : opb_reg;
  assign a_sx       = (mul_op != 2'b11) && mul_a[W-1];
  assign b_sx       = (mul_op == 2'b01) && mul_b[W-1];
  assign mul_a_ext  = {{W{a_sx}}, mul_a};
  assign mul_b_ext  = {{W{b_sx}}, mul_b};
  assign product    = mul_a_ext * mul_b_ext;
  assign mul_result = (mul_op == 2'b00) ? product[W-1:0] : product[2*W-1:W];

  assign rem_shift = {rem_reg, opa_reg[W-1]};
  assign diff      = rem_shift - {1'b0, opb_reg};
  assign q_bit     = !diff[W];
  assign quo_fix   = quo_neg_reg ? -opa_reg : opa_reg;
  assign rem_fix   = rem_neg_reg ? -rem_reg : rem_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    op_next      = op_reg;
    opa_next     = opa_reg;
    opb_next     = opb_reg;
    rem_next     = rem_reg;
    quo_neg_next = quo_neg_reg;
    rem_neg_next = rem_neg_reg;
    result_next  = result_reg;
    tag_next     = tag_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_next  = funct3[1:0];
          opa_next = aluIn1;
          opb_next = aluIn2;
          tag_next = in_tag;
          if (!funct3[2]) begin
            if (MUL_LATENCY == 1) begin
              result_next = mul_result;
              state_next  = DONE;
            end else begin
              cnt_next   = CW'(MUL_LATENCY - 1);
              state_next = MUL;
            end
          end else if (div_by_zero || overflow) begin
            result_next = special_result;
            state_next  = DONE;
          end else begin
            opa_next     = a_mag;
            opb_next     = b_mag;
            rem_next     = '0;
            quo_neg_next = a_neg ^ b_neg;
            rem_neg_next = a_neg;
            cnt_next     = CW'(W);
            state_next   = DIV;
          end
        end
      end
      MUL: begin
        if (cnt_reg <= CW'(1)) begin
          result_next = mul_result;
          state_next  = DONE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      DIV: begin
        // Counter nonzero: one quotient bit; counter zero: sign-fix cycle.
        if (cnt_reg != '0) begin
          rem_next = q_bit ? diff[W-1:0] : rem_shift[W-1:0];
          opa_next = {opa_reg[W-2:0], q_bit};
          cnt_next = cnt_reg - CW'(1);
        end else begin
          result_next = op_reg[1] ? rem_fix : quo_fix;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op_reg      <= '0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      rem_reg     <= '0;
      quo_neg_reg <= 1'b0;
      rem_neg_reg <= 1'b0;
      result_reg  <= '0;
      tag_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      op_reg      <= op_next;
      opa_reg     <= opa_next;
      opb_reg     <= opb_next;
      rem_reg     <= rem_next;
      quo_neg_reg <= quo_neg_next;
      rem_neg_reg <= rem_neg_next;
      result_reg  <= result_next;
      tag_reg     <= tag_next;
    end
  end

endmodule
